hv_pwm_intb_encode: RTL
=======================

HV_PWM_INTB_ENCODE -- requirements
Module: hv_pwm_intb_encode

Interface
REQ-001 The block SHALL have parameter PLS_LO_CYC, default 6, giving the low-phase length of one code pulse in clocks (legal range 5..8).
REQ-002 The block SHALL have parameter PLS_HI_CYC, default 6, giving the high-phase length between pulses of one frame in clocks (legal range 5..8).
REQ-003 The block SHALL have parameter GAP_CYC, default 16, giving the mandatory idle-high length after the final low phase of a frame (legal range 12..255).
REQ-004 Port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port i_en, input, 1 bit: frame-start enable.
REQ-007 Port i_intb_set_req, input, 1 bit: single-cycle request to signal "INTB asserted", sent as a 1-pulse code.
REQ-008 Port i_intb_clr_req, input, 1 bit: single-cycle request to signal "INTB released", sent as a 3-pulse code.
REQ-009 Port o_hv_pwm_intb_n, output, 1 bit: registered PWM INTB line; idles high.
REQ-010 Port o_busy, output, 1 bit: a frame is in progress.
REQ-011 Port o_frame_done, output, 1 bit: single-cycle pulse on the last cycle of a frame.
REQ-012 Port o_tx_intb_n, output, 1 bit: INTB level conveyed by the last completed frame.

Function
REQ-013 The FSM SHALL have states IDLE, PLS_LO, PLS_HI and GAP; o_hv_pwm_intb_n SHALL be low exactly in the cycles where the state is PLS_LO.
REQ-014 Pending flags set_pend and clr_pend SHALL latch their requests; a new request SHALL clear the opposite pending flag (last request wins).
REQ-015 If set and clr requests arrive in the same cycle, set SHALL win: set_pend=1, clr_pend=0.
REQ-016 In IDLE with i_en=1 and any request pending or arriving that cycle, the FSM SHALL enter PLS_LO next cycle and consume the chosen flag.
REQ-017 The frame code SHALL be set if set is pending or arriving, else clr.
REQ-018 The pulse counter SHALL load 1 for a set frame and 3 for a clr frame.
REQ-019 PLS_LO SHALL last PLS_LO_CYC cycles, then go to PLS_HI if pulses remain, else to GAP; PLS_HI SHALL last PLS_HI_CYC cycles, then return to PLS_LO.
REQ-020 GAP SHALL last GAP_CYC cycles, then go to IDLE.
REQ-021 o_frame_done SHALL be asserted in the last GAP cycle.
REQ-022 In the o_frame_done cycle, o_tx_intb_n SHALL be updated to 0 for a set frame or 1 for a clr frame.
REQ-023 o_busy SHALL be high whenever the state is not IDLE.
REQ-024 Requests arriving while busy SHALL only update the pending flags and SHALL never alter the frame in flight; with the default parameters, the next frame SHALL start in PLS_LO two cycles after o_frame_done.
REQ-025 i_en=0 SHALL block new frame starts only; a frame in progress SHALL always complete, with no truncation; pending flags SHALL be held while i_en=0.
REQ-026 A request repeating the current o_tx_intb_n value SHALL still be transmitted as a refresh frame.
REQ-027 Phase counters SHALL be wide enough for max(PLS_LO_CYC, PLS_HI_CYC, GAP_CYC) and SHALL never wrap within a phase.

Reset
REQ-028 When i_rst=1 at a clock edge, the block SHALL enter IDLE and set o_hv_pwm_intb_n=1, o_busy=0, o_frame_done=0, o_tx_intb_n=1, set_pend=0, clr_pend=0 and all counters to 0.
REQ-029 Reset during a frame SHALL abort the frame, drive the line high the next cycle and discard pending requests.

Verification
REQ-030 Set frame: i_en=1, set_req at cycle 0 -> line low cycles 1-6, high from 7; o_frame_done at 22; o_tx_intb_n=0 from 23; o_busy cycles 1-22.
REQ-031 Clr frame: clr_req at cycle 0 -> line low at 1-6, 13-18 and 25-30; o_frame_done at 46; o_tx_intb_n=1 from 47.
REQ-032 Simultaneous set and clr at cycle 0 -> exactly one low pulse; o_tx_intb_n=0; nothing pending afterwards.
REQ-033 set_req at 0, then clr_req at 5 and set_req at 10 -> second frame is set; first low of second frame at cycle 24.
REQ-034 i_en=0 with clr_req pending -> line stays high; i_en=1 at cycle 50 -> first low at 51. Separately, i_en=0 at cycle 3 of a set frame -> that frame still completes.
REQ-035 i_rst=1 at cycle 14 of a clr frame -> line high at 15 with all outputs at reset values; a set_req after reset is released -> normal set frame.

Source files
------------

// File: rtl/hv_pwm_intb_encode.sv
// PWM INTB encoder: sends set (1 low pulse) or clr (3 low pulses) frames.
// Ports: i_clk, i_rst (sync, active-high), i_en, i_intb_set_req,
//   i_intb_clr_req -> o_hv_pwm_intb_n (registered line), o_busy,
//   o_frame_done (last GAP cycle), o_tx_intb_n (level of last frame).
module hv_pwm_intb_encode #(
  parameter int PLS_LO_CYC = 6,
  parameter int PLS_HI_CYC = 6,
  parameter int GAP_CYC    = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_intb_set_req,
  input  logic i_intb_clr_req,
  output logic o_hv_pwm_intb_n,
  output logic o_busy,
  output logic o_frame_done,
  output logic o_tx_intb_n
);

  localparam int MAXLH = (PLS_LO_CYC > PLS_HI_CYC) ? PLS_LO_CYC : PLS_HI_CYC;
  localparam int MAXC  = (MAXLH > GAP_CYC) ? MAXLH : GAP_CYC;
  localparam int CW    = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE,
    PLS_LO,
    PLS_HI,
    GAP
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]  pls, pls_n;
  logic        code_set, code_set_n;
  logic        set_pend, set_pend_n;
  logic        clr_pend, clr_pend_n;
  logic        tx, tx_n;
  logic        line;
  logic        pick_set;
  logic        last_lo, last_hi, last_gap;

  assign last_lo  = (cnt == CW'(PLS_LO_CYC - 1));
  assign last_hi  = (cnt == CW'(PLS_HI_CYC - 1));
  assign last_gap = (cnt == CW'(GAP_CYC - 1));
  assign pick_set = set_pend | i_intb_set_req;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pls_n      = pls;
    code_set_n = code_set;
    tx_n       = tx;
    set_pend_n = set_pend;
    clr_pend_n = clr_pend;
    // Latest request wins; set wins a same-cycle tie.
    if (i_intb_set_req) begin
      set_pend_n = 1'b1;
      clr_pend_n = 1'b0;
    end else if (i_intb_clr_req) begin
      clr_pend_n = 1'b1;
      set_pend_n = 1'b0;
    end
    unique case (state)
      IDLE: begin
        if (i_en && (set_pend | clr_pend |
                     i_intb_set_req | i_intb_clr_req)) begin
          state_n    = PLS_LO;
          cnt_n      = '0;
          code_set_n = pick_set;
          pls_n      = pick_set ? 2'd1 : 2'd3;
          if (pick_set) set_pend_n = 1'b0;
          else          clr_pend_n = 1'b0;
        end
      end
      PLS_LO: begin
        if (last_lo) begin
          cnt_n = '0;
          if (pls > 2'd1) begin
            pls_n   = pls - 2'd1;
            state_n = PLS_HI;
          end else begin
            pls_n   = 2'd0;
            state_n = GAP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PLS_HI: begin
        if (last_hi) begin
          cnt_n   = '0;
          state_n = PLS_LO;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (last_gap) begin
          cnt_n   = '0;
          state_n = IDLE;
          tx_n    = ~code_set;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pls      <= 2'd0;
      code_set <= 1'b0;
      set_pend <= 1'b0;
      clr_pend <= 1'b0;
      tx       <= 1'b1;
      line     <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pls      <= pls_n;
      code_set <= code_set_n;
      set_pend <= set_pend_n;
      clr_pend <= clr_pend_n;
      tx       <= tx_n;
      // Line is registered from the next state so it tracks PLS_LO exactly.
      line     <= (state_n != PLS_LO);
    end
  end

  assign o_hv_pwm_intb_n = line;
  assign o_busy          = (state != IDLE);
  assign o_frame_done    = (state == GAP) && last_gap;
  assign o_tx_intb_n     = tx;

endmodule
